// File: rtl/sim_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : sim_event_monitor
//  Purpose  : Host-side monitor for simulation-control requests raised by a
//             synthesised DUT. Owns the DUT run-enable and cycle counter,
//             captures stop/finish requests into a one-entry event register
//             drained by the host over valid/ready, pauses on stop, resumes
//             on host command and halts for good after a drain period on
//             finish.
//  Revision : 1.0 - initial release
// ============================================================================
module sim_event_monitor #(
    parameter int CYCLE_W      = 32,
    parameter int CODE_W       = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               finish_req,
    input  logic               stop_req,
    input  logic [CODE_W-1:0]  req_code,
    input  logic               resume,
    output logic               run_en,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [1:0]         evt_type,
    output logic [CODE_W-1:0]  evt_code,
    output logic [CYCLE_W-1:0] evt_cycle,
    output logic               finished,
    output logic               overflow
);

    // Drain counter must hold DRAIN_CYCLES; keep at least one bit when it is 0.
    localparam int c_DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_STOPPED  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN    = 2'd2;
    localparam logic [1:0] c_ST_FINISHED = 2'd3;

    localparam logic [1:0] c_EVT_NONE   = 2'b00;
    localparam logic [1:0] c_EVT_STOP   = 2'b01;
    localparam logic [1:0] c_EVT_FINISH = 2'b10;

    logic [1:0]           r_state;
    logic [c_DRAIN_W-1:0] r_drain_cnt;
    logic                 r_finish_prev;
    logic                 r_stop_prev;
    logic                 r_run_en;
    logic                 r_finished;
    logic [CYCLE_W-1:0]   r_cycle_count;
    logic                 r_evt_valid;
    logic [1:0]           r_evt_type;
    logic [CODE_W-1:0]    r_evt_code;
    logic [CYCLE_W-1:0]   r_evt_cycle;
    logic                 r_overflow;

    logic                 w_finish_edge;
    logic                 w_stop_edge;
    logic                 w_pop;
    logic                 w_capture;
    logic [1:0]           w_cap_type;

    // Edge detection and capture decision; only RUN accepts requests, finish beats stop.
    always_comb begin
        w_finish_edge = finish_req & ~r_finish_prev;
        w_stop_edge   = stop_req & ~r_stop_prev;
        w_pop         = r_evt_valid & evt_ready;
        w_capture     = 1'b0;
        w_cap_type    = c_EVT_NONE;
        if (r_state == c_ST_RUN) begin
            if (w_finish_edge) begin
                w_capture  = 1'b1;
                w_cap_type = c_EVT_FINISH;
            end else if (w_stop_edge) begin
                w_capture  = 1'b1;
                w_cap_type = c_EVT_STOP;
            end
        end
    end

    // Previous-cycle request copies track every cycle so a held level never retriggers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_finish_prev <= 1'b0;
            r_stop_prev   <= 1'b0;
        end else begin
            r_finish_prev <= finish_req;
            r_stop_prev   <= stop_req;
        end
    end

    // Free-running DUT cycle counter, advancing only while the DUT is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_count <= '0;
        end else if (r_run_en) begin
            r_cycle_count <= r_cycle_count + CYCLE_W'(1);
        end
    end

    // Control state machine with registered run-enable and finished flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_RUN;
            r_drain_cnt <= '0;
            r_run_en    <= 1'b1;
            r_finished  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_finish_edge) begin
                        if (DRAIN_CYCLES == 0) begin
                            r_state    <= c_ST_FINISHED;
                            r_run_en   <= 1'b0;
                            r_finished <= 1'b1;
                        end else begin
                            r_state     <= c_ST_DRAIN;
                            r_drain_cnt <= c_DRAIN_LOAD;
                        end
                    end else if (w_stop_edge) begin
                        r_state  <= c_ST_STOPPED;
                        r_run_en <= 1'b0;
                    end
                end
                c_ST_STOPPED: begin
                    if (resume) begin
                        r_state  <= c_ST_RUN;
                        r_run_en <= 1'b1;
                    end
                end
                c_ST_DRAIN: begin
                    // The cycle that sees the count at one is the last enabled cycle.
                    if (r_drain_cnt <= c_DRAIN_ONE) begin
                        r_state     <= c_ST_FINISHED;
                        r_run_en    <= 1'b0;
                        r_finished  <= 1'b1;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - c_DRAIN_ONE;
                    end
                end
                c_ST_FINISHED: begin
                    r_run_en   <= 1'b0;
                    r_finished <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_FINISHED;
                end
            endcase
        end
    end

    // One-entry event register: load when empty or popping, otherwise drop and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_type  <= c_EVT_NONE;
            r_evt_code  <= '0;
            r_evt_cycle <= '0;
            r_overflow  <= 1'b0;
        end else if (w_capture) begin
            if (!r_evt_valid || w_pop) begin
                r_evt_valid <= 1'b1;
                r_evt_type  <= w_cap_type;
                r_evt_code  <= req_code;
                r_evt_cycle <= r_cycle_count;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (w_pop) begin
            r_evt_valid <= 1'b0;
            r_evt_type  <= c_EVT_NONE;
        end
    end

    assign run_en      = r_run_en;
    assign cycle_count = r_cycle_count;
    assign evt_valid   = r_evt_valid;
    assign evt_type    = r_evt_type;
    assign evt_code    = r_evt_code;
    assign evt_cycle   = r_evt_cycle;
    assign finished    = r_finished;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sim_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sim_event_monitor
//  Purpose  : Self-checking bench for sim_event_monitor: directed scenarios
//             plus randomized traffic, all compared every cycle against a
//             behavioural model built on a mode variable and an event queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sim_event_monitor;

    localparam int P_CYCLE_W = 32;
    localparam int P_CODE_W  = 8;
    localparam int P_DRAIN   = 2;

    localparam int M_RUN   = 0;
    localparam int M_STOP  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_FIN   = 3;

    typedef struct {
        logic [1:0]           t;
        logic [P_CODE_W-1:0]  c;
        logic [P_CYCLE_W-1:0] cy;
    } ev_t;

    logic                 clk;
    logic                 rst_n;
    logic                 finish_req;
    logic                 stop_req;
    logic [P_CODE_W-1:0]  req_code;
    logic                 resume;
    logic                 run_en;
    logic [P_CYCLE_W-1:0] cycle_count;
    logic                 evt_valid;
    logic                 evt_ready;
    logic [1:0]           evt_type;
    logic [P_CODE_W-1:0]  evt_code;
    logic [P_CYCLE_W-1:0] evt_cycle;
    logic                 finished;
    logic                 overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int                   m_mode;
    int                   m_drain_left;
    logic [P_CYCLE_W-1:0] m_count;
    bit                   m_over;
    bit                   m_fin_prev;
    bit                   m_stop_prev;
    ev_t                  m_q[$];

    sim_event_monitor #(
        .CYCLE_W     (P_CYCLE_W),
        .CODE_W      (P_CODE_W),
        .DRAIN_CYCLES(P_DRAIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .finish_req (finish_req),
        .stop_req   (stop_req),
        .req_code   (req_code),
        .resume     (resume),
        .run_en     (run_en),
        .cycle_count(cycle_count),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_type   (evt_type),
        .evt_code   (evt_code),
        .evt_cycle  (evt_cycle),
        .finished   (finished),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode       = M_RUN;
        m_drain_left = 0;
        m_count      = '0;
        m_over       = 1'b0;
        m_fin_prev   = 1'b0;
        m_stop_prev  = 1'b0;
        m_q.delete();
    endtask

    // One clock of behaviour, applied with the inputs the DUT sampled.
    task automatic model_step();
        bit  fe;
        bit  se;
        bit  running;
        bit  have_new;
        ev_t e;
        fe       = finish_req && !m_fin_prev;
        se       = stop_req && !m_stop_prev;
        running  = (m_mode == M_RUN) || (m_mode == M_DRAIN);
        have_new = 1'b0;
        e        = '{2'b00, '0, '0};
        if (m_q.size() != 0 && evt_ready) m_q.delete(0);
        case (m_mode)
            M_RUN: begin
                if (fe) begin
                    e            = '{2'b10, req_code, m_count};
                    have_new     = 1'b1;
                    m_drain_left = P_DRAIN;
                    m_mode       = (P_DRAIN == 0) ? M_FIN : M_DRAIN;
                end else if (se) begin
                    e        = '{2'b01, req_code, m_count};
                    have_new = 1'b1;
                    m_mode   = M_STOP;
                end
            end
            M_STOP: if (resume) m_mode = M_RUN;
            M_DRAIN: begin
                m_drain_left--;
                if (m_drain_left == 0) m_mode = M_FIN;
            end
            default: ;
        endcase
        if (have_new) begin
            if (m_q.size() == 0) m_q.push_back(e);
            else m_over = 1'b1;
        end
        if (running) m_count = m_count + 1;
        m_fin_prev  = finish_req;
        m_stop_prev = stop_req;
    endtask

    // Event payload is only meaningful while an event is held.
    task automatic compare_all(input string tag);
        logic [127:0]         obs;
        logic [127:0]         exp;
        logic [1:0]           et;
        logic [P_CODE_W-1:0]  ec;
        logic [P_CYCLE_W-1:0] ey;
        logic [P_CODE_W-1:0]  oc;
        logic [P_CYCLE_W-1:0] oy;
        bit                   v;
        v  = (m_q.size() != 0);
        et = 2'b00; ec = '0; ey = '0; oc = '0; oy = '0;
        if (v) begin
            et = m_q[0].t; ec = m_q[0].c; ey = m_q[0].cy;
            oc = evt_code; oy = evt_cycle;
        end
        exp = {50'd0, ((m_mode == M_RUN) || (m_mode == M_DRAIN)), (m_mode == M_FIN),
               m_over, v, et, ec, m_count, ey};
        obs = {50'd0, run_en, finished, overflow, evt_valid, evt_type, oc, cycle_count, oy};
        check_eq($sformatf("%s@%0t {run,fin,ovf,vld,type,code,cnt,cyc}", tag, $time), obs, exp);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        finish_req = 1'b0;
        stop_req   = 1'b0;
        req_code   = '0;
        resume     = 1'b0;
        evt_ready  = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; finish_req = 1'b0; stop_req = 1'b0;
        req_code = '0; resume = 1'b0; evt_ready = 1'b0;
        model_reset();

        // Reset state and idle running
        do_reset();
        check_eq("rst_run_en", run_en, 1);
        check_eq("rst_count", cycle_count, 0);
        check_eq("rst_valid", evt_valid, 0);
        check_eq("rst_type", evt_type, 0);
        check_eq("rst_fin_ovf", {finished, overflow}, 0);
        for (int i = 0; i < 10; i++) step("idle");
        check_eq("idle_count", cycle_count, 10);
        check_eq("idle_flags", {run_en, evt_valid, finished}, 3'b100);

        // Stop, drain the event, resume with stop still high
        do_reset();
        for (int i = 0; i < 4; i++) step("pre_stop");
        stop_req = 1'b1; req_code = 8'h11;
        step("stop_cap");
        check_eq("stop_run_en", run_en, 0);
        check_eq("stop_evt", {evt_valid, evt_type, evt_code}, {1'b1, 2'b01, 8'h11});
        check_eq("stop_evt_cycle", evt_cycle, 4);
        step("stopped");
        step("stopped");
        check_eq("stop_count_frozen", cycle_count, 5);
        evt_ready = 1'b1; step("pop"); evt_ready = 1'b0;
        check_eq("pop_valid", evt_valid, 0);
        resume = 1'b1; step("resume"); resume = 1'b0;
        check_eq("resume_run_en", run_en, 1);
        step("after_resume");
        step("after_resume");
        check_eq("resume_no_evt", evt_valid, 0);
        check_eq("resume_count", cycle_count, 7);
        stop_req = 1'b0;

        // Finish with drain, then terminal
        do_reset();
        for (int i = 0; i < 5; i++) step("pre_fin");
        finish_req = 1'b1; req_code = 8'h5A;
        step("fin_cap");
        check_eq("fin_drain_run1", run_en, 1);
        step("drain");
        check_eq("fin_drain_run2", run_en, 1);
        step("drain");
        check_eq("fin_halt", {run_en, finished}, 2'b01);
        resume = 1'b1; step("fin_resume"); resume = 1'b0;
        step("fin_hold");
        check_eq("fin_count", cycle_count, 8);
        check_eq("fin_evt", {evt_type, evt_code}, {2'b10, 8'h5A});
        check_eq("fin_evt_cycle", evt_cycle, 5);
        check_eq("fin_still", {run_en, finished}, 2'b01);
        finish_req = 1'b0;

        // Simultaneous finish and stop
        do_reset();
        for (int i = 0; i < 3; i++) step("pre_both");
        finish_req = 1'b1; stop_req = 1'b1; req_code = 8'h33;
        step("both");
        check_eq("both_evt", {evt_valid, evt_type, overflow, run_en, finished}, {1'b1, 2'b10, 1'b0, 1'b1, 1'b0});
        step("both_drain");
        step("both_drain");
        check_eq("both_done", {finished, overflow}, 2'b10);
        finish_req = 1'b0; stop_req = 1'b0;

        // Overflow with the register full
        do_reset();
        step("ov"); step("ov");
        stop_req = 1'b1; req_code = 8'hA1; step("ov_stop1");
        stop_req = 1'b0; step("ov");
        resume = 1'b1; step("ov_resume"); resume = 1'b0;
        stop_req = 1'b1; req_code = 8'hB2; step("ov_stop2");
        check_eq("ovf_set", overflow, 1);
        check_eq("ovf_retained", {evt_code, evt_cycle}, {8'hA1, 32'd2});
        stop_req = 1'b0;

        // Second capture coincides with a pop
        do_reset();
        step("ld"); step("ld");
        stop_req = 1'b1; req_code = 8'hA1; step("ld_stop1");
        stop_req = 1'b0; step("ld");
        resume = 1'b1; step("ld_resume"); resume = 1'b0;
        stop_req = 1'b1; req_code = 8'hB2; evt_ready = 1'b1; step("ld_stop2");
        evt_ready = 1'b0;
        check_eq("ld_no_ovf", {overflow, evt_valid}, 2'b01);
        check_eq("ld_new_evt", {evt_code, evt_cycle}, {8'hB2, 32'd3});
        stop_req = 1'b0;

        // Asynchronous reset during drain with a pending event
        do_reset();
        step("ar"); step("ar");
        finish_req = 1'b1; step("ar_fin");
        check_eq("ar_pre", {evt_valid, run_en}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_async", {run_en, evt_valid, finished, overflow}, 4'b1000);
        check_eq("ar_count", cycle_count, 0);
        model_reset();
        finish_req = 1'b0;
        @(negedge clk);
        compare_all("ar_hold");
        rst_n = 1'b1;
        step("ar_after");
        step("ar_after");

        // Randomized traffic
        for (int ep = 0; ep < 12; ep++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(3) == 0) stop_req = ~stop_req;
                if ($urandom_range(39) == 0) finish_req = ~finish_req;
                req_code  = P_CODE_W'($urandom);
                resume    = ($urandom_range(4) == 0);
                evt_ready = ($urandom_range(2) == 0);
                step("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
